uart_rx_ctrl: RTL

UART receive controller for the iCE40 serial path. It sequences a mid-bit baud tick generator: the generator is enabled only while a frame is in flight, and each tick samples one bit. Incoming 8-bit frames are assembled LSB first, and each byte is presented with a one-cycle strobe plus error flags. The block sits between the `rx` pad and the command/loopback logic that consumes received bytes.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_bit_timer.sv | 31 +++
 rtl/uart_rx_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Parity support is compiled in when UART_RX_PARITY_EN is defined.
package uart_pkg;

  // Receiver sequencing states; PARITY is only visited when parity is compiled in.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Clock cycles per bit for common baud rates at 12 MHz.
  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B38400  = 313;
  localparam int B19200  = 625;
  localparam int B9600   = 1250;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Mid-bit baud tick generator: free-runs only while enabled and fires
// once per bit period, half a bit after the enable rises.
module uart_rx_bit_timer #(
  parameter int BAUDDIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  output logic tick
);

  localparam int CW = $clog2(BAUDDIV);

  logic [CW-1:0] count;

  // Bit-period counter, held at zero while the receiver is idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst || !ena) begin
      count <= '0;
    end else if (count == CW'(BAUDDIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = ena && (count == CW'(BAUDDIV >> 1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 2-FF input synchronizer, frame FSM driving a
// gated mid-bit timer, and registered byte/error outputs with a 1-cycle strobe.
// Define UART_RX_PARITY_EN to receive start + 8 data + parity + stop frames;
// otherwise frames are 8N1 and par_err is held at 0.
module uart_rx_ctrl #(
  parameter int BAUDDIV    = 104,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rcv,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       par_err,
  output logic       busy
);

  import uart_pkg::*;

  logic [1:0] sync;
  logic       rx_s;
  state_t     state;
  state_t     state_next;
  logic       ena;
  logic       tick;
  logic [2:0] bit_cnt;
  logic [7:0] sr;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Two-flop synchronizer for the asynchronous pad; resets to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];

  uart_rx_bit_timer #(
    .BAUDDIV (BAUDDIV)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: every transition after start detection waits for a tick.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_next = state;
    case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: if (tick)  state_next = rx_s ? IDLE : DATA;
      DATA: begin
        if (tick && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) state_next = STOP;
`endif
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: timer runs and busy is shown whenever a frame is in flight.
  always_comb begin
    busy = (state != IDLE);
    ena  = busy;
  end

  // Datapath: bit assembly on ticks, outputs updated only on the stop tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      sr        <= '0;
      data      <= '0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      rcv       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      rcv <= 1'b0;
      if (tick) begin
        case (state)
          START: bit_cnt <= '0;
          DATA: begin
            sr      <= {rx_s, sr[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
`ifdef UART_RX_PARITY_EN
          PARITY: par_bit <= rx_s;
`endif
          STOP: begin
            data      <= sr;
            frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            par_err   <= ((^sr) ^ par_bit) != PARITY_ODD;
`else
            par_err   <= 1'b0;
`endif
            rcv       <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
